mul_share_ctrl: RTL

Two-requester scheduler and pipeline controller for the shared 32x32 Booth multiplier in the execute stage. Arbitrates round-robin between two issue lanes, performs sign handling around the unsigned multiplier core, and registers the 64-bit product plus a selected 32-bit word and flags. Uses a valid/busy handshake on both sides, with flush support for pipeline kills.

---
 rtl/mul_share_ctrl_pkg.sv | 16 +
 rtl/mul_share_ctrl_mul_booth32.sv | 40 ++++
 rtl/mul_share_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mul_share_ctrl_pkg.sv
// Shared constants and types for the multiplier scheduler: lane ids, widths, operand helpers.
package mul_share_ctrl_pkg;
  localparam int TAG_W_DEF = 5;
  localparam int PROD_W    = 64;
  localparam int WORD_W    = 32;

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_e;

  // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
  function automatic logic [WORD_W-1:0] abs32(input logic [WORD_W-1:0] v);
    return v[WORD_W-1] ? (~v + 32'd1) : v;
  endfunction
endpackage

// File: rtl/mul_share_ctrl_mul_booth32.sv
// Unsigned 32x32 radix-4 Booth multiplier core (combinational), shared by both issue lanes.
module mul_booth32
  import mul_share_ctrl_pkg::*;
(
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  output logic [PROD_W-1:0] product_o,
  output logic              sf_o,
  output logic              zf_o
);
  logic [WORD_W+2:0] mr_s;
  logic [PROD_W-1:0] mcand_s;
  logic [PROD_W-1:0] pp_s;
  logic [PROD_W-1:0] acc_s;
  logic [2:0]        dig_s;

  // Two zero pad bits on the multiplier keep the top digit non-negative for unsigned operands.
  always_comb begin
    mcand_s = {32'd0, a_i};
    mr_s    = {2'b00, b_i, 1'b0};
    acc_s   = 64'd0;
    pp_s    = 64'd0;
    dig_s   = 3'd0;
    for (int i = 0; i < 17; i++) begin
      dig_s = 3'(mr_s >> (2 * i));
      case (dig_s)
        3'b001, 3'b010: pp_s = mcand_s;
        3'b011:         pp_s = mcand_s << 1;
        3'b100:         pp_s = ~(mcand_s << 1) + 64'd1;
        3'b101, 3'b110: pp_s = ~mcand_s + 64'd1;
        default:        pp_s = 64'd0;
      endcase
      acc_s = acc_s + (pp_s << (2 * i));
    end
  end

  assign product_o = acc_s;
  assign sf_o      = acc_s[PROD_W-1];
  assign zf_o      = (acc_s == 64'd0);
endmodule

// File: rtl/mul_share_ctrl.sv
// Round-robin two-lane scheduler and 2-stage pipeline around the shared Booth multiplier.
// Signed operation is built only when MUL_SHARE_CTRL_SIGNED_EN is defined.
module mul_share_ctrl
  import mul_share_ctrl_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic              iCLOCK,
  input  logic              iRESET_SYNC,
  input  logic              iFLUSH,
  input  logic              iREQ0_VALID,
  output logic              oREQ0_BUSY,
  input  logic              iREQ0_SIGNED,
  input  logic              iREQ0_HIGH,
  input  logic [TAG_W-1:0]  iREQ0_TAG,
  input  logic [WORD_W-1:0] iREQ0_DATA_0,
  input  logic [WORD_W-1:0] iREQ0_DATA_1,
  input  logic              iREQ1_VALID,
  output logic              oREQ1_BUSY,
  input  logic              iREQ1_SIGNED,
  input  logic              iREQ1_HIGH,
  input  logic [TAG_W-1:0]  iREQ1_TAG,
  input  logic [WORD_W-1:0] iREQ1_DATA_0,
  input  logic [WORD_W-1:0] iREQ1_DATA_1,
  output logic              oOUT_VALID,
  input  logic              iOUT_BUSY,
  output logic              oOUT_ID,
  output logic [TAG_W-1:0]  oOUT_TAG,
  output logic [PROD_W-1:0] oOUT_PRODUCT,
  output logic [WORD_W-1:0] oOUT_DATA,
  output logic              oOUT_SF,
  output logic              oOUT_ZF
);
  logic adv1_s, adv2_s, kill_s, gnt0_s, gnt1_s, gnt_any_s;
  lane_e last_q, last_d;

  logic              s1_valid_q, s1_valid_d, s1_high_q, s1_high_d;
  logic [WORD_W-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
  lane_e             s1_id_q, s1_id_d;

  logic              out_valid_q, out_valid_d, out_sf_q, out_sf_d, out_zf_q, out_zf_d;
  lane_e             out_id_q, out_id_d;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d;
  logic [PROD_W-1:0] out_prod_q, out_prod_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;

  logic [WORD_W-1:0] req_a_s, req_b_s, mag_a_s, mag_b_s, word_s;
  logic [PROD_W-1:0] mul_prod_s, prod_s;
  logic              unused_booth_sf_s, unused_booth_zf_s;

  assign adv2_s    = !out_valid_q || !iOUT_BUSY;
  assign adv1_s    = !s1_valid_q || adv2_s;
  assign kill_s    = iRESET_SYNC || iFLUSH;
  assign gnt_any_s = gnt0_s || gnt1_s;

  // Arbiter: a tie goes to the lane that did not win last time.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (!adv1_s || kill_s) begin
      gnt0_s = 1'b0;
    end else if (iREQ0_VALID && iREQ1_VALID) begin
      if (last_q == LANE1) begin
        gnt0_s = 1'b1;
      end else begin
        gnt1_s = 1'b1;
      end
    end else if (iREQ0_VALID) begin
      gnt0_s = 1'b1;
    end else if (iREQ1_VALID) begin
      gnt1_s = 1'b1;
    end else begin
      gnt0_s = 1'b0;
    end
  end

  assign oREQ0_BUSY = !adv1_s || kill_s || gnt1_s;
  assign oREQ1_BUSY = !adv1_s || kill_s || gnt0_s;
  assign req_a_s    = gnt1_s ? iREQ1_DATA_0 : iREQ0_DATA_0;
  assign req_b_s    = gnt1_s ? iREQ1_DATA_1 : iREQ0_DATA_1;

`ifdef MUL_SHARE_CTRL_SIGNED_EN
  logic req_signed_s, s1_neg_q, s1_neg_d;
  assign req_signed_s = gnt1_s ? iREQ1_SIGNED : iREQ0_SIGNED;
  assign mag_a_s      = req_signed_s ? abs32(req_a_s) : req_a_s;
  assign mag_b_s      = req_signed_s ? abs32(req_b_s) : req_b_s;
  assign s1_neg_d     = gnt_any_s ? (req_signed_s && (req_a_s[31] ^ req_b_s[31])) : s1_neg_q;
  assign prod_s       = s1_neg_q ? (~mul_prod_s + 64'd1) : mul_prod_s;

  // Result sign travels with the S1 operands.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      s1_neg_q <= 1'b0;
    end else begin
      s1_neg_q <= s1_neg_d;
    end
  end
`else
  logic unused_signed_s;
  assign unused_signed_s = iREQ0_SIGNED ^ iREQ1_SIGNED;
  assign mag_a_s         = req_a_s;
  assign mag_b_s         = req_b_s;
  assign prod_s          = mul_prod_s;
`endif

  mul_booth32 u_mul (
    .a_i       (s1_a_q),
    .b_i       (s1_b_q),
    .product_o (mul_prod_s),
    .sf_o      (unused_booth_sf_s),
    .zf_o      (unused_booth_zf_s)
  );

  assign word_s = s1_high_q ? prod_s[63:32] : prod_s[31:0];

  // Next-state for the pointer, S1 and S2; reset outranks flush, flush outranks transfers.
  always_comb begin
    last_d      = gnt1_s ? LANE1 : (gnt0_s ? LANE0 : last_q);
    s1_valid_d  = s1_valid_q;
    s1_a_d      = gnt_any_s ? mag_a_s : s1_a_q;
    s1_b_d      = gnt_any_s ? mag_b_s : s1_b_q;
    s1_high_d   = gnt_any_s ? (gnt1_s ? iREQ1_HIGH : iREQ0_HIGH) : s1_high_q;
    s1_tag_d    = gnt_any_s ? (gnt1_s ? iREQ1_TAG : iREQ0_TAG) : s1_tag_q;
    s1_id_d     = gnt_any_s ? (gnt1_s ? LANE1 : LANE0) : s1_id_q;
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_tag_d   = out_tag_q;
    out_prod_d  = out_prod_q;
    out_data_d  = out_data_q;
    out_sf_d    = out_sf_q;
    out_zf_d    = out_zf_q;
    if (kill_s) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (adv1_s) begin
        s1_valid_d = gnt_any_s;
      end else begin
        s1_valid_d = s1_valid_q;
      end
      if (adv2_s) begin
        out_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          out_id_d   = s1_id_q;
          out_tag_d  = s1_tag_q;
          out_prod_d = prod_s;
          out_data_d = word_s;
          out_sf_d   = word_s[WORD_W-1];
          out_zf_d   = (word_s == 32'd0);
        end else begin
          out_id_d = out_id_q;
        end
      end else begin
        out_valid_d = out_valid_q;
      end
    end
  end

  // State registers.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      last_q      <= LANE1;
      s1_valid_q  <= 1'b0;
      s1_a_q      <= 32'd0;
      s1_b_q      <= 32'd0;
      s1_high_q   <= 1'b0;
      s1_tag_q    <= '0;
      s1_id_q     <= LANE0;
      out_valid_q <= 1'b0;
      out_id_q    <= LANE0;
      out_tag_q   <= '0;
      out_prod_q  <= 64'd0;
      out_data_q  <= 32'd0;
      out_sf_q    <= 1'b0;
      out_zf_q    <= 1'b0;
    end else begin
      last_q      <= last_d;
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_high_q   <= s1_high_d;
      s1_tag_q    <= s1_tag_d;
      s1_id_q     <= s1_id_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_tag_q   <= out_tag_d;
      out_prod_q  <= out_prod_d;
      out_data_q  <= out_data_d;
      out_sf_q    <= out_sf_d;
      out_zf_q    <= out_zf_d;
    end
  end

  assign oOUT_VALID   = out_valid_q;
  assign oOUT_ID      = out_id_q;
  assign oOUT_TAG     = out_tag_q;
  assign oOUT_PRODUCT = out_prod_q;
  assign oOUT_DATA    = out_data_q;
  assign oOUT_SF      = out_sf_q;
  assign oOUT_ZF      = out_zf_q;
endmodule
